// File: rtl/dag_path_counter.sv
// dag_path_counter: counts distinct start->end paths in a layered DAG using a merging, CAM-searched ring work queue.
// Rev 1.0
`default_nettype none

module dag_path_counter #(
  parameter int NODE_W = 10,
  parameter int ACC_W  = 24,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [NODE_W-1:0] start_node,
  input  logic [NODE_W-1:0] end_node,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output logic              acc_ovf,
  output logic              q_ovf,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [NODE_W-1:0] req_node,
  input  logic              rsp_valid,
  input  logic [NODE_W-1:0] rsp_node,
  input  logic              rsp_last,
  input  logic              rsp_none
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_POP  = 3'd2,
    ST_REQ  = 3'd3,
    ST_EDGE = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  state_t state, state_nx;

  logic [NODE_W-1:0] q_node [DEPTH];
  logic [ACC_W-1:0]  q_cnt  [DEPTH];
  logic [DEPTH-1:0]  q_vld;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    occ;

  logic [NODE_W-1:0] s_node, e_node, cur_node;
  logic [ACC_W-1:0]  cur_cnt, end_acc;

  logic              empty, full, run_abort, beat, is_end, hit;
  logic              do_end, do_hit, do_push, do_drop;
  logic [PTR_W-1:0]  hit_idx;
  logic [ACC_W:0]    sum_end, sum_hit;
  logic [ACC_W-1:0]  sat_end, sat_hit;

  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;
  logic [NODE_W-1:0] wr_node;
  logic [ACC_W-1:0]  wr_cnt;

  assign empty     = (occ == '0);
  assign full      = (occ == FULL_OCC);
  assign run_abort = abort && (state != ST_IDLE);
  assign beat      = (state == ST_EDGE) && rsp_valid;
  assign is_end    = (rsp_node == e_node);

  // A node is never queued twice while valid, so at most one entry matches.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i] && (q_node[i] == rsp_node)) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  assign do_end  = beat && !rsp_none && is_end;
  assign do_hit  = beat && !rsp_none && !is_end && hit;
  assign do_push = beat && !rsp_none && !is_end && !hit && !full;
  assign do_drop = beat && !rsp_none && !is_end && !hit && full;

  assign sum_end = {1'b0, end_acc} + {1'b0, cur_cnt};
  assign sum_hit = {1'b0, q_cnt[hit_idx]} + {1'b0, cur_cnt};
  assign sat_end = sum_end[ACC_W] ? '1 : sum_end[ACC_W-1:0];
  assign sat_hit = sum_hit[ACC_W] ? '1 : sum_hit[ACC_W-1:0];

  // Single write port shared by the INIT seed, appends and in-place merges.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = wr_ptr;
    wr_node = rsp_node;
    wr_cnt  = cur_cnt;
    if ((state == ST_INIT) && (s_node != e_node)) begin
      wr_en   = 1'b1;
      wr_node = s_node;
      wr_cnt  = ACC_W'(1);
    end else if (do_push) begin
      wr_en = 1'b1;
    end else if (do_hit) begin
      wr_en  = 1'b1;
      wr_idx = hit_idx;
      wr_cnt = sat_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      q_node[wr_idx] <= wr_node;
      q_cnt[wr_idx]  <= wr_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_INIT;
      ST_INIT: state_nx = (s_node == e_node) ? ST_DONE : ST_POP;
      ST_POP:  state_nx = empty ? ST_DONE : ST_REQ;
      ST_REQ:  if (req_ready) state_nx = ST_EDGE;
      ST_EDGE: if (rsp_valid && (rsp_last || rsp_none)) state_nx = ST_POP;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (run_abort) state_nx = ST_IDLE;
  end

  assign req_valid = (state == ST_REQ);
  assign req_node  = cur_node;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      acc_ovf  <= 1'b0;
      q_ovf    <= 1'b0;
      q_vld    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      s_node   <= '0;
      e_node   <= '0;
      cur_node <= '0;
      cur_cnt  <= '0;
      end_acc  <= '0;
    end else begin
      done <= 1'b0;
      if (run_abort) begin
        busy   <= 1'b0;
        q_vld  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              busy    <= 1'b1;
              acc_ovf <= 1'b0;
              q_ovf   <= 1'b0;
              end_acc <= '0;
              q_vld   <= '0;
              wr_ptr  <= '0;
              rd_ptr  <= '0;
              occ     <= '0;
              s_node  <= start_node;
              e_node  <= end_node;
            end
          end
          ST_INIT: begin
            if (s_node == e_node) begin
              end_acc <= ACC_W'(1);
            end else begin
              q_vld[wr_ptr] <= 1'b1;
              wr_ptr        <= wr_ptr + 1'b1;
              occ           <= occ + 1'b1;
            end
          end
          ST_POP: begin
            if (!empty) begin
              cur_node      <= q_node[rd_ptr];
              cur_cnt       <= q_cnt[rd_ptr];
              q_vld[rd_ptr] <= 1'b0;
              rd_ptr        <= rd_ptr + 1'b1;
              occ           <= occ - 1'b1;
            end
          end
          ST_EDGE: begin
            if (do_end) begin
              end_acc <= sat_end;
              if (sum_end[ACC_W]) acc_ovf <= 1'b1;
            end
            if (do_hit && sum_hit[ACC_W]) acc_ovf <= 1'b1;
            if (do_push) begin
              q_vld[wr_ptr] <= 1'b1;
              wr_ptr        <= wr_ptr + 1'b1;
              occ           <= occ + 1'b1;
            end
            if (do_drop) q_ovf <= 1'b1;
          end
          ST_DONE: begin
            result <= end_acc;
            done   <= 1'b1;
            busy   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
